// File: rtl/cfg_loader_pkg.sv
// Shared types and widths for the config stream loader.
// Pair layout carried through the FIFO and the loader FSM encoding.
// No logic lives here.
package cfg_loader_pkg;

  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 32;
  localparam logic [CFG_ADDR_W-1:0] CFG_NOP_ADDR = 32'h0;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
    logic                  last;
  } cfg_pair_t;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_DONE = 1'b1
  } ld_state_t;

endpackage

// File: rtl/cfg_fifo.sv
// DEPTH-entry FIFO of config pairs; head entry is readable combinationally.
// Latency: a push is visible at the head on the cycle after its edge.
// Backpressure: push while full and pop while empty are ignored.
module cfg_fifo
  import cfg_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  cfg_pair_t push_dat_i,
  input  logic      pop_i,
  output cfg_pair_t pop_dat_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  cfg_pair_t       mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            do_push;
  logic            do_pop;

  // Extra pointer MSB distinguishes a full wrap from empty.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is always refused.
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset flushes the FIFO by equalising the pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/cfg_stream_loader.sv
// Buffers host (addr,data) config pairs and issues one per cycle to the PE tile config port.
// Latency: pair pushed into an empty FIFO at edge N appears on config_addr/data at edge N+1.
// Backpressure: in_ready low when FIFO full, once last is accepted, or while DONE.
module cfg_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] TILE_ID   = 16'h15,
  parameter bit          FILTER_EN = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CFG_ADDR_W-1:0] in_addr,
  input  logic [CFG_DATA_W-1:0] in_data,
  input  logic                  in_last,
  input  logic                  cfg_hold,
  input  logic                  clear_done,
  output logic [CFG_ADDR_W-1:0] config_addr,
  output logic [CFG_DATA_W-1:0] config_data,
  output logic                  config_done,
  output logic [15:0]           word_count
);

  ld_state_t             state_q, state_d;
  logic [CFG_ADDR_W-1:0] addr_q, addr_d;
  logic [CFG_DATA_W-1:0] data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  last_seen_q, last_seen_d;

  cfg_pair_t             wr_pair;
  cfg_pair_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  issue;
  logic                  keep;

  assign wr_pair  = '{addr: in_addr, data: in_data, last: in_last};
  // Once the last pair is accepted nothing more may enter until the stream is cleared.
  assign in_ready = !fifo_full && (state_q == LD_LOAD) && !last_seen_q;
  assign push     = in_valid && in_ready;
  assign keep     = !FILTER_EN || (head.addr[15:0] == TILE_ID);

  cfg_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_i      (reset),
    .push_i     (push),
    .push_dat_i (wr_pair),
    .pop_i      (issue),
    .pop_dat_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // State, output pair, counter and last-accepted flag registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= LD_LOAD;
      addr_q      <= CFG_NOP_ADDR;
      data_q      <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Next state: issue/filter the head pair in LOAD, wait for clear_done in DONE.
  always_comb begin
    state_d     = state_q;
    addr_d      = CFG_NOP_ADDR;
    data_d      = '0;
    cnt_d       = cnt_q;
    last_seen_d = last_seen_q;
    issue       = 1'b0;
    case (state_q)
      LD_LOAD: begin
        if (push && in_last) last_seen_d = 1'b1;
        if (!fifo_empty && !cfg_hold) begin
          issue = 1'b1;
          // Filtered pairs are consumed but drive a no-op and are not counted.
          if (keep) begin
            addr_d = head.addr;
            data_d = head.data;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
          if (head.last) state_d = LD_DONE;
        end
      end
      LD_DONE: begin
        if (clear_done) begin
          state_d     = LD_LOAD;
          cnt_d       = '0;
          last_seen_d = 1'b0;
        end
      end
      default: state_d = LD_LOAD;
    endcase
  end

  assign config_addr = addr_q;
  assign config_data = data_q;
  assign config_done = (state_q == LD_DONE);
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: one unfiltered and one filtering instance share inputs.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each comparison is an immediate assertion; a summary line closes the run.
module tb_cfg_stream_loader;
  import cfg_loader_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        cfg_hold = 1'b0;
  logic        clear_done = 1'b0;

  logic        in_ready, f_in_ready;
  logic [31:0] config_addr, f_config_addr;
  logic [31:0] config_data, f_config_data;
  logic        config_done, f_config_done;
  logic [15:0] word_count, f_word_count;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  cfg_stream_loader #(.DEPTH(4), .TILE_ID(16'h15), .FILTER_EN(1'b0)) dut (
    .clk_in(clk_in), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last), .cfg_hold(cfg_hold),
    .clear_done(clear_done), .config_addr(config_addr), .config_data(config_data),
    .config_done(config_done), .word_count(word_count)
  );

  cfg_stream_loader #(.DEPTH(4), .TILE_ID(16'h15), .FILTER_EN(1'b1)) dut_f (
    .clk_in(clk_in), .reset(reset), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last), .cfg_hold(cfg_hold),
    .clear_done(clear_done), .config_addr(f_config_addr), .config_data(f_config_data),
    .config_done(f_config_done), .word_count(f_word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, config_addr, a);
    chk({tag, "_data"}, config_data, d);
  endtask

  task automatic pulse_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    cfg_hold   = 1'b0;
    clear_done = 1'b0;
    reset      = 1'b1;
    #1;
    reset      = 1'b0;
  endtask

  initial begin
    // Test 1: reset state
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    chk_out("t1_rst", 32'h0, 32'h0);
    chk("t1_done", {31'b0, config_done}, 32'd0);
    chk("t1_wc", {16'b0, word_count}, 32'd0);
    chk("t1_rdy", {31'b0, in_ready}, 32'd1);
    @(negedge clk_in);

    // Test 2: three back-to-back pairs, last on the third
    drive(1'b1, 32'h0000_0015, 32'hAAAA_0001, 1'b0);
    tick();
    chk_out("t2_pre", 32'h0, 32'h0);
    drive(1'b1, 32'h0001_0015, 32'h0000_BEEF, 1'b0);
    tick();
    chk_out("t2_p0", 32'h0000_0015, 32'hAAAA_0001);
    drive(1'b1, 32'h0002_0015, 32'h1234_5678, 1'b1);
    tick();
    chk_out("t2_p1", 32'h0001_0015, 32'h0000_BEEF);
    chk("t2_rdy_after_last", {31'b0, in_ready}, 32'd0);
    chk("t2_done_early", {31'b0, config_done}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk_out("t2_p2", 32'h0002_0015, 32'h1234_5678);
    chk("t2_done", {31'b0, config_done}, 32'd1);
    chk("t2_wc", {16'b0, word_count}, 32'd3);
    chk("t2_rdy_done", {31'b0, in_ready}, 32'd0);
    tick();
    chk_out("t2_idle", 32'h0, 32'h0);
    chk("t2_done_hold", {31'b0, config_done}, 32'd1);

    // Test 3: hold while filling past DEPTH, then drain
    pulse_reset();
    cfg_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {16'(i + 1), 16'h0015}, 32'hC0DE_0000 + 32'(i), 1'b0);
      chk($sformatf("t3_rdy%0d", i), {31'b0, in_ready}, 32'd1);
      tick();
      chk_out($sformatf("t3_held%0d", i), 32'h0, 32'h0);
    end
    drive(1'b1, 32'h0005_0015, 32'hC0DE_0004, 1'b1);
    chk("t3_rdy_full", {31'b0, in_ready}, 32'd0);
    tick();
    chk("t3_rdy_full2", {31'b0, in_ready}, 32'd0);
    chk_out("t3_held_full", 32'h0, 32'h0);
    cfg_hold = 1'b0;
    tick();
    chk_out("t3_q0", 32'h0001_0015, 32'hC0DE_0000);
    chk("t3_rdy_drain", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("t3_q1", 32'h0002_0015, 32'hC0DE_0001);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk_out("t3_q2", 32'h0003_0015, 32'hC0DE_0002);
    tick();
    chk_out("t3_q3", 32'h0004_0015, 32'hC0DE_0003);
    chk("t3_done_early", {31'b0, config_done}, 32'd0);
    tick();
    chk_out("t3_q4", 32'h0005_0015, 32'hC0DE_0004);
    chk("t3_done", {31'b0, config_done}, 32'd1);
    chk("t3_wc", {16'b0, word_count}, 32'd5);

    // Test 4: filtering instance drops a foreign address
    pulse_reset();
    drive(1'b1, 32'h0000_0016, 32'h0000_FFFF, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0015, 32'h0000_0001, 1'b1);
    tick();
    chk("t4_f_addr0", f_config_addr, 32'h0);
    chk("t4_f_data0", f_config_data, 32'h0);
    chk("t4_f_wc0", {16'b0, f_word_count}, 32'd0);
    chk_out("t4_nofilt0", 32'h0000_0016, 32'h0000_FFFF);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("t4_f_addr1", f_config_addr, 32'h0000_0015);
    chk("t4_f_data1", f_config_data, 32'h0000_0001);
    chk("t4_f_wc1", {16'b0, f_word_count}, 32'd1);
    chk("t4_f_done", {31'b0, f_config_done}, 32'd1);
    chk("t4_nofilt_wc", {16'b0, word_count}, 32'd2);

    // Test 5: asynchronous reset mid-stream
    pulse_reset();
    cfg_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0015, 32'h0000_5000 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    cfg_hold = 1'b0;
    tick();
    chk_out("t5_first", 32'h0000_0015, 32'h0000_5000);
    reset = 1'b1;
    #1;
    chk_out("t5_async", 32'h0, 32'h0);
    chk("t5_wc_async", {16'b0, word_count}, 32'd0);
    chk("t5_rdy_async", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("t5_stale%0d", i), 32'h0, 32'h0);
      chk($sformatf("t5_wc%0d", i), {16'b0, word_count}, 32'd0);
    end

    // Test 6: finish a stream, hold in DONE, clear_done, new stream
    drive(1'b1, 32'h0000_0015, 32'h0000_0009, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk_out("t6_a", 32'h0000_0015, 32'h0000_0009);
    chk("t6_done_a", {31'b0, config_done}, 32'd1);
    cfg_hold = 1'b1;
    tick();
    chk_out("t6_hold_done", 32'h0, 32'h0);
    chk("t6_done_hold", {31'b0, config_done}, 32'd1);
    cfg_hold   = 1'b0;
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    chk("t6_done_clr", {31'b0, config_done}, 32'd0);
    chk("t6_wc_clr", {16'b0, word_count}, 32'd0);
    chk("t6_rdy_clr", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h0000_0015, 32'h0000_0007, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t6_done_pre", {31'b0, config_done}, 32'd0);
    tick();
    chk_out("t6_b", 32'h0000_0015, 32'h0000_0007);
    chk("t6_wc_b", {16'b0, word_count}, 32'd1);
    chk("t6_done_b", {31'b0, config_done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
